// File: rtl/miriscv_irq_ctrl.sv
// ---------------------------------------------------------------------------
// miriscv_irq_ctrl
//   Fixed-priority interrupt controller sitting at the far end of the core's
//   interrupt interface. Up to N_IRQ peripheral sources are masked by the
//   core's mie, the lowest enabled index wins, and one source is serviced at
//   a time. The core acknowledges with int_rst_i (mret). The serviced
//   peripheral then gets a one-cycle one-hot irq_ret_o pulse.
//
//   Optional feature macro: MIRISCV_IRQ_EDGE_EN
//     defined   : sources are rising-edge sensitive and latched in pending
//     undefined : sources are level sensitive (default build)
//
// Parameters
//   N_IRQ         number of sources (1..32); index 0 has highest priority
//   CAUSE_OFFSET  added to the winning index to form mcause_o[30:0]
//
// Ports
//   clk_i      clock
//   rst_i      synchronous active-high reset
//   irq_req_i  peripheral interrupt requests
//   irq_ret_o  one-hot one-cycle "serviced" pulse back to the peripheral
//   mie_i      core interrupt-enable mask (bits >= N_IRQ ignored)
//   int_rst_i  core acknowledge: handler finished
//   int_o      interrupt request to the core
//   mcause_o   {1'b1, CAUSE_OFFSET+idx} while int_o is high, else 0
// ---------------------------------------------------------------------------
module miriscv_irq_ctrl #(
    parameter int unsigned N_IRQ        = 32,
    parameter int unsigned CAUSE_OFFSET = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N_IRQ-1:0] irq_req_i,
    output logic [N_IRQ-1:0] irq_ret_o,
    input  logic [31:0]      mie_i,
    input  logic             int_rst_i,
    output logic             int_o,
    output logic [31:0]      mcause_o
);

    localparam int unsigned IDX_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               int_q, int_d;
    logic [31:0]        mcause_q, mcause_d;
    logic [N_IRQ-1:0]   ret_q, ret_d;

    logic [N_IRQ-1:0]   src;
    logic [N_IRQ-1:0]   eligible;
    logic [IDX_W-1:0]   win_idx;
    logic [N_IRQ-1:0]   idx_onehot;

    // One-hot decode of the latched index, used for the return pulse and
    // for clearing the pending bit of the serviced source.
    for (genvar gi = 0; gi < N_IRQ; gi++) begin : g_onehot
        assign idx_onehot[gi] = (idx_q == IDX_W'(gi));
    end

`ifdef MIRISCV_IRQ_EDGE_EN
    logic [N_IRQ-1:0] irq_q;
    logic [N_IRQ-1:0] pending_q, pending_d;
    logic [N_IRQ-1:0] rise;
    logic             ack;

    assign rise = irq_req_i & ~irq_q;
    assign ack  = (state_q == BUSY) && int_rst_i;

    // A rise arriving on the same edge as the acknowledge of that source
    // must not be lost, so the set term is OR-ed in after the clear.
    always_comb begin
        pending_d = (pending_q & ~(ack ? idx_onehot : '0)) | rise;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            irq_q     <= '0;
            pending_q <= '0;
        end else begin
            irq_q     <= irq_req_i;
            pending_q <= pending_d;
        end
    end

    assign src = pending_q;
`else
    assign src = irq_req_i;
`endif

    assign eligible = src & mie_i[N_IRQ-1:0];

    // Scan from the top down so the lowest set index is the last writer.
    always_comb begin
        win_idx = '0;
        for (int i = int'(N_IRQ) - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        int_d    = int_q;
        mcause_d = mcause_q;
        ret_d    = '0;
        case (state_q)
            IDLE: begin
                if (|eligible) begin
                    state_d  = BUSY;
                    idx_d    = win_idx;
                    int_d    = 1'b1;
                    mcause_d = {1'b1, 31'(CAUSE_OFFSET) + 31'(win_idx)};
                end
            end
            BUSY: begin
                // Mask and source changes are ignored here; only the
                // acknowledge ends the service of the latched index.
                if (int_rst_i) begin
                    state_d  = IDLE;
                    int_d    = 1'b0;
                    mcause_d = '0;
                    ret_d    = idx_onehot;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            int_q    <= 1'b0;
            mcause_q <= '0;
            ret_q    <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            int_q    <= int_d;
            mcause_q <= mcause_d;
            ret_q    <= ret_d;
        end
    end

    assign int_o     = int_q;
    assign mcause_o  = mcause_q;
    assign irq_ret_o = ret_q;

endmodule
